// File: rtl/bus_arbiter_rr_pkg.sv
// Shared definitions for the round-robin bus arbiter: FSM states, hold counter
// width, active-low level names and the owner index width helper.
package bus_arbiter_rr_pkg;

    typedef enum logic {
        ST_GRANT = 1'b0,
        ST_GAP   = 1'b1
    } arb_state_t;

    localparam int unsigned HOLD_W = 8;

    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    function automatic int unsigned owner_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Rotate-priority search: returns the first asserted request at or after i_start,
// wrapping modulo N.
module bus_arb_rr_pick #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 2
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_start,
    output logic         o_found,
    output logic [W-1:0] o_idx
);

    function automatic logic [W:0] f_pick(input logic [N-1:0] req, input logic [W-1:0] start);
        logic           found;
        logic [W-1:0]   idx;
        int unsigned    j;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            j = (int'(start) + k) % N;
            if (!found && req[j]) begin
                found = 1'b1;
                idx   = W'(j);
            end
        end
        return {found, idx};
    endfunction

    always_comb begin
        {o_found, o_idx} = f_pick(i_req, i_start);
    end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Round-robin system bus arbiter with per-owner hold limit, lock override and an
// optional one-cycle idle gap on every ownership change.
module bus_arbiter_rr
    import bus_arbiter_rr_pkg::*;
#(
    parameter  int unsigned NUM_MASTERS  = 4,
    parameter  int unsigned MAX_HOLD     = 0,
    parameter  int unsigned HANDOVER_GAP = 0,
    localparam int unsigned OWNER_W      = owner_width(NUM_MASTERS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_MASTERS-1:0] req_,
    input  logic [NUM_MASTERS-1:0] lock_,
    output logic [NUM_MASTERS-1:0] grnt_,
    output logic [OWNER_W-1:0]     owner,
    output logic                   bus_idle
);

    localparam logic [HOLD_W-1:0] HOLD_LIM = (MAX_HOLD == 0) ? '0 : HOLD_W'(MAX_HOLD - 1);

    arb_state_t               r_state;
    logic [OWNER_W-1:0]       r_owner;
    logic [HOLD_W-1:0]        r_hold;
    logic [NUM_MASTERS-1:0]   r_grnt_;
    logic                     r_idle;

    logic [NUM_MASTERS-1:0]   w_req;
    logic [NUM_MASTERS-1:0]   w_others;
    logic [OWNER_W-1:0]       w_start;
    logic                     w_owner_req;
    logic                     w_owner_lock;
    logic                     w_timeout;
    logic                     w_found;
    logic [OWNER_W-1:0]       w_next;

    function automatic logic [NUM_MASTERS-1:0] f_onehot(input logic [OWNER_W-1:0] idx);
        return NUM_MASTERS'(1) << idx;
    endfunction

    always_comb begin
        w_req        = ~req_;
        w_others     = w_req & ~f_onehot(r_owner);
        w_start      = (r_owner == OWNER_W'(NUM_MASTERS - 1)) ? '0 : OWNER_W'(r_owner + 1'b1);
        w_owner_req  = w_req[r_owner];
        w_owner_lock = (lock_[r_owner] == ENABLE_);
        w_timeout    = (MAX_HOLD != 0) && (r_hold >= HOLD_LIM) && !w_owner_lock && (|w_others);
    end

    // The owner is masked out of the search so parking and handover fall out of w_found.
    bus_arb_rr_pick #(
        .N (NUM_MASTERS),
        .W (OWNER_W)
    ) u_pick (
        .i_req   (w_others),
        .i_start (w_start),
        .o_found (w_found),
        .o_idx   (w_next)
    );

    // Grant/idle are registered from the next-state values, so they always match
    // a decode of the registered owner and state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_GRANT;
            r_owner <= '0;
            r_hold  <= '0;
            r_grnt_ <= ~f_onehot('0);
            r_idle  <= 1'b0;
        end else begin
            case (r_state)
                ST_GAP: begin
                    r_state <= ST_GRANT;
                    r_grnt_ <= ~f_onehot(r_owner);
                    r_idle  <= 1'b0;
                end
                default: begin
                    if (w_owner_req && !w_timeout) begin
                        r_hold <= (r_hold == '1) ? r_hold : r_hold + 1'b1;
                    end else if (w_found) begin
                        r_owner <= w_next;
                        r_hold  <= '0;
                        if (HANDOVER_GAP != 0) begin
                            r_state <= ST_GAP;
                            r_grnt_ <= '1;
                            r_idle  <= 1'b1;
                        end else begin
                            r_grnt_ <= ~f_onehot(w_next);
                        end
                    end else begin
                        r_hold <= '0;
                    end
                end
            endcase
        end
    end

    assign grnt_    = r_grnt_;
    assign owner    = r_owner;
    assign bus_idle = r_idle;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Directed bench for bus_arbiter_rr: vector table on a no-gap instance
// (N=4, MAX_HOLD=4) plus hand sequences on a HANDOVER_GAP=1 instance.
module tb_bus_arbiter_rr;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst,  g_rst;
    logic [3:0] req_, lock_, g_req_, g_lock_;
    logic [3:0] grnt_, g_grnt_;
    logic [1:0] owner, g_owner;
    logic       bus_idle, g_idle;

    int tests = 0;
    int fails = 0;

    bus_arbiter_rr #(.NUM_MASTERS(4), .MAX_HOLD(4), .HANDOVER_GAP(0)) u_dut (
        .clk(clk), .rst(rst), .req_(req_), .lock_(lock_),
        .grnt_(grnt_), .owner(owner), .bus_idle(bus_idle)
    );

    bus_arbiter_rr #(.NUM_MASTERS(4), .MAX_HOLD(4), .HANDOVER_GAP(1)) u_gap (
        .clk(clk), .rst(g_rst), .req_(g_req_), .lock_(g_lock_),
        .grnt_(g_grnt_), .owner(g_owner), .bus_idle(g_idle)
    );

    typedef struct {
        logic [3:0] req_;
        logic [3:0] lock_;
        logic [3:0] grnt_;
        logic [1:0] owner;
    } vec_t;

    vec_t vt[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] r, input logic [3:0] l, input logic [3:0] g,
                       input logic [1:0] o, input int n);
        for (int i = 0; i < n; i++) vt.push_back('{r, l, g, o});
    endtask

    initial begin
        // rotation, including wrap from m3 to m0
        add(4'b0101, 4'hF, 4'b1101, 2'd1, 2);
        add(4'b0111, 4'hF, 4'b0111, 2'd3, 1);
        add(4'b1110, 4'hF, 4'b1110, 2'd0, 1);
        // m0 and m2 contend: 4-cycle slices
        for (int i = 0; i < 12; i++) begin
            if (((i + 1) / 4) % 2 == 0) add(4'b1010, 4'hF, 4'b1110, 2'd0, 1);
            else                        add(4'b1010, 4'hF, 4'b1011, 2'd2, 1);
        end
        add(4'b1110, 4'hF, 4'b1110, 2'd0, 1);
        // lock holds m0 past the limit, release hands over at once
        add(4'b1100, 4'b1110, 4'b1110, 2'd0, 10);
        add(4'b1100, 4'hF,    4'b1101, 2'd1, 1);
        // m1 alone builds hold count, parking must clear it
        add(4'b1101, 4'hF, 4'b1101, 2'd1, 3);
        add(4'b1111, 4'hF, 4'b1101, 2'd1, 5);
        add(4'b1100, 4'hF, 4'b1101, 2'd1, 3);
        add(4'b1100, 4'hF, 4'b1110, 2'd0, 1);
        // simultaneous requests resolved by rotation distance
        add(4'b0001, 4'hF, 4'b1101, 2'd1, 1);
        add(4'b0011, 4'hF, 4'b1011, 2'd2, 1);
        add(4'b0110, 4'hF, 4'b0111, 2'd3, 1);
        add(4'b1000, 4'hF, 4'b1110, 2'd0, 1);

        rst = 1'b1; g_rst = 1'b1;
        lock_ = 4'hF; g_lock_ = 4'hF; g_req_ = 4'hF;
        req_ = 4'($urandom);
        tick();
        req_ = 4'($urandom);
        tick();
        chk("reset_grnt",  32'(grnt_), 32'(4'b1110));
        chk("reset_owner", 32'(owner), 32'd0);
        chk("reset_idle",  32'(bus_idle), 32'd0);
        rst = 1'b0;
        req_ = 4'hF;

        for (int i = 0; i < vt.size(); i++) begin
            req_  = vt[i].req_;
            lock_ = vt[i].lock_;
            tick();
            chk($sformatf("vec%0d_grnt", i),  32'(grnt_),    32'(vt[i].grnt_));
            chk($sformatf("vec%0d_owner", i), 32'(owner),    32'(vt[i].owner));
            chk($sformatf("vec%0d_idle", i),  32'(bus_idle), 32'd0);
        end

        // gap instance: handover 0 -> 2 with one idle cycle
        tick();
        chk("gap_reset_grnt", 32'(g_grnt_), 32'(4'b1110));
        g_rst = 1'b0;
        g_req_ = 4'b1011;
        tick();
        chk("gap_idle_grnt",  32'(g_grnt_), 32'(4'b1111));
        chk("gap_idle_flag",  32'(g_idle),  32'd1);
        chk("gap_idle_owner", 32'(g_owner), 32'd2);
        tick();
        chk("gap_after_grnt", 32'(g_grnt_), 32'(4'b1011));
        chk("gap_after_idle", 32'(g_idle),  32'd0);

        // pending owner is granted even if it drops during the gap
        g_req_ = 4'b1101;
        tick();
        chk("gap2_idle_owner", 32'(g_owner), 32'd1);
        chk("gap2_idle_flag",  32'(g_idle),  32'd1);
        g_req_ = 4'hF;
        tick();
        chk("gap2_drop_grnt",  32'(g_grnt_), 32'(4'b1101));
        tick();
        chk("gap2_park_grnt",  32'(g_grnt_), 32'(4'b1101));

        // reset while in a gap cycle
        g_req_ = 4'b0111;
        tick();
        chk("gap3_idle_flag",  32'(g_idle),  32'd1);
        chk("gap3_idle_owner", 32'(g_owner), 32'd3);
        g_rst = 1'b1;
        tick();
        chk("gaprst_grnt",  32'(g_grnt_), 32'(4'b1110));
        chk("gaprst_owner", 32'(g_owner), 32'd0);
        chk("gaprst_idle",  32'(g_idle),  32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
